imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter MEM_WORDS, default 32: number of 32-bit words in the instruction memory; valid byte range is 0 .. 4*MEM_WORDS-1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_addr  out  bus_type (32)  byte address driven to the combinational instruction memory.
REQ-006 imem_rdata  in  bus_type (32)  word returned by memory for imem_addr in the same cycle.
REQ-007 redirect_valid  in  1  branch/jump redirect request.
REQ-008 redirect_pc  in  32  redirect target byte address.
REQ-009 halt_req  in  1  request to stop fetching.
REQ-010 out_valid  out  1  instruction available to decode.
REQ-011 out_ready  in  1  decode accepts instruction.
REQ-012 out_instr  out  32  instruction word at FIFO head.
REQ-013 out_pc  out  32  byte address of out_instr.
REQ-014 fault  out  1  sticky fetch fault flag.
REQ-015 state  out  2  FSM state: 0 RUN, 1 HALTED, 2 FAULT.

Function
REQ-016 Internal state: PC register, 2-entry FIFO of {pc, instr}, FSM {RUN, HALTED, FAULT}.
REQ-017 imem_addr shall equal the PC register at all times.
REQ-018 Fetch condition: state RUN, PC in range, no redirect_valid, and FIFO count < 2 or a pop occurs this cycle.
REQ-019 On a fetch edge, {PC, imem_rdata} is pushed and PC advances by 4; otherwise PC holds.
REQ-020 out_valid = (count != 0) and not redirect_valid; out_instr/out_pc show the FIFO head.
REQ-021 A pop occurs when out_valid and out_ready are both high at the edge; simultaneous push and pop when full keeps count at 2.
REQ-022 Latency: an instruction fetched at edge N appears on out_valid in the cycle after edge N (one cycle).
REQ-023 redirect_valid with redirect_pc 4-aligned and in range: flush FIFO, PC <= redirect_pc, no push or pop that edge, state <= RUN (from RUN or HALTED).
REQ-024 redirect_valid with redirect_pc misaligned (bits[1:0] != 0) or out of range: flush FIFO, state <= FAULT, fault <= 1, PC holds.
REQ-025 halt_req in RUN without redirect_valid: state <= HALTED at that edge, no push that edge; FIFO contents remain drainable.
REQ-026 Redirect has priority over halt_req when both are asserted the same cycle.
REQ-027 In RUN with PC out of range (e.g. after the last word, PC = 4*MEM_WORDS): no fetch, state <= FAULT, fault <= 1; FIFO contents remain drainable; no wrap to address 0.
REQ-028 FAULT is terminal; only reset exits it, and all redirect/halt inputs are ignored.
REQ-029 HALTED performs no fetch; halt_req held in HALTED has no effect.

Reset
REQ-030 While rst_n = 0, asynchronously: PC = RESET_PC, FIFO empty, state = RUN, fault = 0, out_valid = 0.
REQ-031 Reset asserted mid-operation discards FIFO contents and any pending redirect or halt; the first fetch occurs at the first rising edge with rst_n = 1.

Verification
REQ-032 Reset release, out_ready = 1, memory word i = 32'h1000_0000+i -> out_valid from cycle 1, out_pc 0,4,8,... with matching instr, one per cycle.
REQ-033 out_ready = 0 for 5 cycles after reset -> count saturates at 2, PC = 8, imem_addr = 8; then out_ready = 1 -> pcs 0,4,8 delivered in order with no gaps or duplicates.
REQ-034 redirect_valid = 1, redirect_pc = 0x40 while FIFO is full -> out_valid = 0 that cycle, next out_pc = 0x40, old entries never appear.
REQ-035 redirect_pc = 0x42 -> state = 2, fault = 1, out_valid = 0; later redirect to 0x0 -> still FAULT.
REQ-036 Sequential run to PC = 0x7C (MEM_WORDS = 32) -> 0x7C delivered, then state = FAULT, fault = 1, imem_addr = 0x80.
REQ-037 halt_req pulse, then redirect to 0x10 -> FIFO drains, no new fetches while HALTED, fetching resumes at 0x10 in RUN; rst_n pulse mid-stream -> out_valid = 0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch front end: PC register, two-entry {pc, instr} buffer toward decode,
// and a RUN/HALTED/FAULT controller for redirects, halts and address faults.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // 33-bit limit so a large MEM_WORDS cannot overflow the byte-range compare
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) << 2;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        fault_q;

  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        pc_in_range;
  logic        redirect_ok;
  logic        fifo_full;
  logic        pop;
  logic        fetch;
  logic        flush;

  assign pc_in_range = ({1'b0, pc_q} < PC_LIMIT);
  assign redirect_ok = (redirect_pc[1:0] == 2'b00) && ({1'b0, redirect_pc} < PC_LIMIT);
  assign fifo_full   = (count == 2'd2);

  assign out_valid = (count != 2'd0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_instr[rd_ptr];

  assign imem_addr = pc_q;
  assign fault     = fault_q;
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_q | (state_d == FAULT);
    end
  end

  // Redirect outranks everything; a bad PC in RUN faults before a halt is honoured
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    fetch   = 1'b0;
    case (state_q)
      RUN, HALTED: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_ok) begin
            pc_d    = redirect_pc;
            state_d = RUN;
          end else begin
            state_d = FAULT;
          end
        end else if (state_q == RUN) begin
          if (!pc_in_range) begin
            state_d = FAULT;
          end else if (halt_req) begin
            state_d = HALTED;
          end else if (!fifo_full || pop) begin
            fetch = 1'b1;
            pc_d  = pc_q + 32'd4;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (fetch) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({fetch, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Buffer storage needs no reset: count gates visibility. When full with a pop,
  // wr_ptr equals rd_ptr, so the departing head slot is the one overwritten.
  always_ff @(posedge clk) begin
    if (fetch) begin
      fifo_pc[wr_ptr]    <= pc_q;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a queue-based fetch model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_WORDS = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  entry_t      mq[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_state = 0;
  logic        m_fault = 1'b0;

  imem_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .state          (state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a < 32'(MEM_WORDS * 4)) return 32'h1000_0000 + (a >> 2);
    return 32'hBAD0_0000;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a queue of fetched words; popping before the push check covers "room or pop"
  task automatic modelStep();
    logic m_valid;
    if (!rst_n) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_state = 0;
      m_fault = 1'b0;
      return;
    end
    m_valid = (mq.size() != 0) && !redirect_valid;
    if (m_state != 2 && redirect_valid) begin
      mq.delete();
      if (redirect_pc % 4 == 0 && redirect_pc < 32'(MEM_WORDS * 4)) begin
        m_pc    = redirect_pc;
        m_state = 0;
      end else begin
        m_state = 2;
        m_fault = 1'b1;
      end
    end else begin
      if (m_valid && out_ready) void'(mq.pop_front());
      if (m_state == 0) begin
        if (m_pc >= 32'(MEM_WORDS * 4)) begin
          m_state = 2;
          m_fault = 1'b1;
        end else if (halt_req) begin
          m_state = 1;
        end else if (mq.size() < 2) begin
          mq.push_back('{pc: m_pc, instr: memWord(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    modelStep();
  end

  always @(negedge clk) begin
    logic m_valid;
    m_valid = (mq.size() != 0) && !redirect_valid;
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      checkOutput("out_pc", out_pc, mq[0].pc);
      checkOutput("out_instr", out_instr, mq[0].instr);
    end
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("state", 32'(state), 32'(m_state));
    checkOutput("fault", 32'(fault), 32'(m_fault));
  end

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic hr, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    out_ready      = rdy;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_state", 32'(state), 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    runCycles(2);
    checkOutput("init_out_valid", 32'(out_valid), 32'h0);
    checkOutput("init_imem_addr", imem_addr, 32'h0);
    checkOutput("init_state", 32'(state), 32'h0);
    rst_n = 1'b1;

    // Stalled decode: buffer saturates at two entries
    runCycles(5);
    checkOutput("stall_imem_addr", imem_addr, 32'h8);
    checkOutput("stall_out_pc", out_pc, 32'h0);
    checkOutput("stall_out_instr", out_instr, 32'h1000_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    runCycles(1);
    checkOutput("drain_out_pc", out_pc, 32'h4);
    runCycles(5);
    checkOutput("stream_out_pc", out_pc, 32'h18);
    checkOutput("stream_imem_addr", imem_addr, 32'h20);

    // Redirect while full flushes the buffer
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
    #1;
    checkOutput("redir_out_valid", 32'(out_valid), 32'h0);
    runCycles(1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    runCycles(1);
    checkOutput("redir_out_pc", out_pc, 32'h40);
    checkOutput("redir_out_instr", out_instr, 32'h1000_0010);

    // Halt with a full buffer, drain it, then restart by redirect
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    runCycles(1);
    checkOutput("halt_state", 32'(state), 32'h1);
    checkOutput("halt_imem_addr", imem_addr, 32'h48);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    runCycles(1);
    checkOutput("halt_drain_pc", out_pc, 32'h44);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    runCycles(2);
    checkOutput("halt_empty", 32'(out_valid), 32'h0);
    checkOutput("halt_hold_addr", imem_addr, 32'h48);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b1);
    runCycles(1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("resume_state", 32'(state), 32'h0);
    checkOutput("resume_imem_addr", imem_addr, 32'h10);
    runCycles(1);
    checkOutput("resume_out_pc", out_pc, 32'h10);

    // Redirect wins over a same-cycle halt
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b1);
    runCycles(1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("prio_state", 32'(state), 32'h0);
    checkOutput("prio_imem_addr", imem_addr, 32'h20);
    runCycles(2);

    // Mid-stream reset, then run off the end of memory
    resetPulse();
    runCycles(1);
    checkOutput("restart_out_pc", out_pc, RESET_PC);
    runCycles(31);
    checkOutput("last_out_pc", out_pc, 32'h7C);
    checkOutput("last_out_valid", 32'(out_valid), 32'h1);
    runCycles(1);
    checkOutput("end_state", 32'(state), 32'h2);
    checkOutput("end_fault", 32'(fault), 32'h1);
    checkOutput("end_imem_addr", imem_addr, 32'h80);
    checkOutput("end_out_valid", 32'(out_valid), 32'h0);
    runCycles(2);
    checkOutput("end_no_wrap", imem_addr, 32'h80);

    // Misaligned redirect faults; FAULT ignores later redirects
    resetPulse();
    runCycles(3);
    applyStimulus(1'b1, 32'h42, 1'b0, 1'b1);
    #1;
    checkOutput("misal_out_valid", 32'(out_valid), 32'h0);
    runCycles(1);
    checkOutput("misal_state", 32'(state), 32'h2);
    checkOutput("misal_fault", 32'(fault), 32'h1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
    runCycles(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("fault_sticky_state", 32'(state), 32'h2);
    checkOutput("fault_pc_hold", imem_addr, 32'hC);
    runCycles(2);

    // Aligned but out-of-range redirect also faults
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    resetPulse();
    runCycles(2);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1);
    runCycles(1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("oor_state", 32'(state), 32'h2);
    checkOutput("oor_imem_addr", imem_addr, 32'h8);
    runCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
